// File: rtl/pokey_bus_sequencer_if.sv
// Register-bus bundle for one POKEY: the CPU-side access port and the chip-side bus.
// The sequencer takes the master modport; the CPU/POKEY environment takes the slave.
interface pokey_bus_sequencer_if;
    logic       cpu_cs_n;
    logic       cpu_r_w_n;
    logic [3:0] cpu_a;
    logic [7:0] cpu_d;
    logic       cpu_rdy;

    logic       pk_cs_n;
    logic       pk_r_w_n;
    logic [3:0] pk_a;
    logic [7:0] pk_d;

    modport master (
        input  cpu_cs_n, cpu_r_w_n, cpu_a, cpu_d,
        output cpu_rdy,
        output pk_cs_n, pk_r_w_n, pk_a, pk_d
    );

    modport slave (
        output cpu_cs_n, cpu_r_w_n, cpu_a, cpu_d,
        input  cpu_rdy,
        input  pk_cs_n, pk_r_w_n, pk_a, pk_d
    );
endinterface

// File: rtl/pokey_bus_sequencer.sv
// POKEY register-bus owner: wake delay, fixed init table, then CPU pass-through with
// POTGO strobes slipped into idle bus cycles.
module pokey_bus_sequencer #(
    parameter int         WAKE_CYCLES = 16,
    parameter int         POT_PERIOD  = 1024,
    parameter logic [7:0] AUDCTL_VAL  = 8'h00,
    parameter logic [7:0] SKCTL_VAL   = 8'h03
) (
    input  logic                  phi2,
    input  logic                  reset,
    pokey_bus_sequencer_if.master bus,
    output logic                  init_done,
    output logic                  pot_fire
);

    localparam logic [1:0] ST_WAKE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [15:0] WAKE_LAST = 16'(WAKE_CYCLES - 1);
    localparam bit          POT_EN    = (POT_PERIOD > 0);
    localparam logic [15:0] POT_LAST  = POT_EN ? 16'(POT_PERIOD - 1) : 16'd0;
    localparam logic [3:0]  INIT_LAST = 4'd10;
    localparam logic [3:0]  REG_POTGO = 4'hB;

    logic [1:0]  state_q,    state_d;
    logic [15:0] wake_cnt_q, wake_cnt_d;
    logic [3:0]  init_idx_q, init_idx_d;
    logic [15:0] pot_cnt_q,  pot_cnt_d;
    logic        pot_pend_q, pot_pend_d;

    logic        cpu_sel;
    logic        cpu_wr_potgo;
    logic        pot_wrap;
    logic [11:0] init_entry;

    // Init table: clear regs 0..7, AUDCTL, then SKCTL reset followed by its run value.
    function automatic logic [11:0] init_table(input logic [3:0] idx);
        case (idx)
            4'd8:    init_table = {4'h8, AUDCTL_VAL};
            4'd9:    init_table = {4'hF, 8'h00};
            4'd10:   init_table = {4'hF, SKCTL_VAL};
            default: init_table = {idx, 8'h00};
        endcase
    endfunction

    assign cpu_sel      = !bus.cpu_cs_n;
    assign cpu_wr_potgo = cpu_sel && !bus.cpu_r_w_n && (bus.cpu_a == REG_POTGO);
    assign pot_wrap     = POT_EN && (pot_cnt_q == POT_LAST);
    assign init_entry   = init_table(init_idx_q);

    // NOTE: every output and next-state signal gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        wake_cnt_d   = wake_cnt_q;
        init_idx_d   = init_idx_q;
        pot_cnt_d    = pot_cnt_q;
        pot_pend_d   = pot_pend_q;
        bus.pk_cs_n  = 1'b1;
        bus.pk_r_w_n = 1'b1;
        bus.pk_a     = 4'h0;
        bus.pk_d     = 8'h00;
        bus.cpu_rdy  = 1'b0;
        init_done    = 1'b0;
        pot_fire     = 1'b0;

        case (state_q)
            ST_WAKE: begin
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = ST_INIT;
                    init_idx_d = 4'd0;
                end else begin
                    wake_cnt_d = wake_cnt_q + 16'd1;
                end
            end

            ST_INIT: begin
                bus.pk_cs_n  = 1'b0;
                bus.pk_r_w_n = 1'b0;
                bus.pk_a     = init_entry[11:8];
                bus.pk_d     = init_entry[7:0];
                if (init_idx_q == INIT_LAST) begin
                    state_d    = ST_RUN;
                    pot_cnt_d  = 16'd0;
                    pot_pend_d = 1'b0;
                end else begin
                    init_idx_d = init_idx_q + 4'd1;
                end
            end

            ST_RUN: begin
                bus.cpu_rdy = 1'b1;
                init_done   = 1'b1;

                if (!POT_EN || pot_wrap) pot_cnt_d = 16'd0;
                else                     pot_cnt_d = pot_cnt_q + 16'd1;

                // The CPU always owns the bus when selected; POTGO only fills gaps.
                if (cpu_sel) begin
                    bus.pk_cs_n  = 1'b0;
                    bus.pk_r_w_n = bus.cpu_r_w_n;
                    bus.pk_a     = bus.cpu_a;
                    bus.pk_d     = bus.cpu_d;
                end else if (pot_pend_q) begin
                    bus.pk_cs_n  = 1'b0;
                    bus.pk_r_w_n = 1'b0;
                    bus.pk_a     = REG_POTGO;
                    bus.pk_d     = 8'h00;
                    pot_fire     = 1'b1;
                end

                // A CPU POTGO already restarts the pots, so it absorbs any pending request.
                if (cpu_wr_potgo)  pot_pend_d = 1'b0;
                else if (pot_wrap) pot_pend_d = 1'b1;
                else if (pot_fire) pot_pend_d = 1'b0;
            end

            default: state_d = ST_WAKE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge value of its _d, independent of statement order.
    always_ff @(posedge phi2) begin
        if (reset) begin
            state_q    <= ST_WAKE;
            wake_cnt_q <= 16'd0;
            init_idx_q <= 4'd0;
            pot_cnt_q  <= 16'd0;
            pot_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            init_idx_q <= init_idx_d;
            pot_cnt_q  <= pot_cnt_d;
            pot_pend_q <= pot_pend_d;
        end
    end

endmodule
